// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/accumulate unit: operation codes,
// FSM states and the default datapath width.
package hilo_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_MADD  = 3'b010,
        OP_MSUB  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/hilo_if.sv
// Request/result bundle between the EX-stage issue logic and the HI/LO unit.
interface hilo_if
    import hilo_pkg::*;
#(
    parameter int W = DATA_W
) ();

    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/hilo_mult_unit_iter_mult_core.sv
// Unsigned W x W radix-2 shift-add multiplier: one multiplier bit per step,
// W steps after a load; product is 2*W bits wide.
module iter_mult_core
    import hilo_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic [2*W-1:0] product,
    output logic           done
);

    localparam int CW = $clog2(W) + 1;

    logic [2*W-1:0] mcand_r;
    logic [W-1:0]   mplier_r;
    logic [2*W-1:0] prod_r;
    logic [CW-1:0]  cnt_r;

    // done flags the step that consumes the last multiplier bit
    assign done    = step && (cnt_r == CW'(W - 1));
    assign product = prod_r;

    // shift-add datapath and step counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            prod_r   <= {(2*W){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (load) begin
            mcand_r  <= {{W{1'b0}}, mcand};
            mplier_r <= mplier;
            prod_r   <= {(2*W){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (step) begin
            if (mplier_r[0]) begin
                prod_r <= prod_r + mcand_r;
            end else begin
                prod_r <= prod_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CW'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            prod_r   <= prod_r;
            cnt_r    <= cnt_r;
        end
    end

endmodule

// File: rtl/hilo_mult_unit.sv
// EX-stage HI/LO register pair with an iterative multiply/accumulate engine
// (mult, multu, madd, msub, mthi, mtlo); Busy stalls the pipeline during a multiply.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W = hilo_pkg::DATA_W
) (
    input  logic clk,
    input  logic reset,
    hilo_if.slave bus
);

    state_e              state_r, state_n;
    logic [2:0]          op_r;
    logic                neg_r;
    logic                busy_r, done_r;
    logic [DATA_W-1:0]   hi_r, lo_r;

    logic                load_s, step_s, commit_s, mthi_s, mtlo_s;
    logic                signed_s, neg_s, last_s;
    logic [DATA_W-1:0]   a_mag_s, b_mag_s;
    logic [2*DATA_W-1:0] prod_s, p_s, res_s;

    // signed ops multiply magnitudes and re-apply the sign in FIX
    assign signed_s = (bus.op != OP_MULTU);
    assign a_mag_s  = (signed_s && bus.a[DATA_W-1]) ? -bus.a : bus.a;
    assign b_mag_s  = (signed_s && bus.b[DATA_W-1]) ? -bus.b : bus.b;
    assign neg_s    = signed_s && (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);

    iter_mult_core #(.W(DATA_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .step    (step_s),
        .mcand   (a_mag_s),
        .mplier  (b_mag_s),
        .product (prod_s),
        .done    (last_s)
    );

    // FSM next-state and control strobes
    always_comb begin
        state_n  = state_r;
        load_s   = 1'b0;
        step_s   = 1'b0;
        commit_s = 1'b0;
        mthi_s   = 1'b0;
        mtlo_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            load_s  = 1'b1;
                            state_n = ST_CALC;
                        end
                        OP_MTHI: mthi_s = 1'b1;
                        OP_MTLO: mtlo_s = 1'b1;
                        default: state_n = ST_IDLE;
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CALC: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_n = ST_FIX;
                end else begin
                    state_n = ST_CALC;
                end
            end
            ST_FIX: begin
                commit_s = 1'b1;
                state_n  = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // signed product and 64-bit wrap-around accumulate into {HI,LO}
    always_comb begin
        p_s = neg_r ? -prod_s : prod_s;
        case (op_r)
            OP_MADD: res_s = {hi_r, lo_r} + p_s;
            OP_MSUB: res_s = {hi_r, lo_r} - p_s;
            default: res_s = p_s;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // latched op context, HI/LO and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= 3'b000;
            neg_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= {DATA_W{1'b0}};
            lo_r   <= {DATA_W{1'b0}};
        end else begin
            done_r <= commit_s | mthi_s | mtlo_s;
            if (load_s) begin
                op_r   <= bus.op;
                neg_r  <= neg_s;
                busy_r <= 1'b1;
            end else if (commit_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (commit_s) begin
                {hi_r, lo_r} <= res_s;
            end else if (mthi_s) begin
                hi_r <= bus.a;
            end else if (mtlo_s) begin
                lo_r <= bus.a;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed self-checking bench for hilo_mult_unit: hand-computed {HI,LO},
// latency, Busy length, ignored requests and asynchronous abort.
module tb_hilo_mult_unit;
    import hilo_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edges, busy_cnt, done_cnt;

    always #5 clk = ~clk;

    hilo_if #(.W(32)) bus ();

    hilo_mult_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // edge 1 is the accepting edge; operands are scrambled right after it
    task automatic wait_done(input bit inject, output int e, output int bc);
        e  = 0;
        bc = 0;
        while (e < 100) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (e == 1) begin
                bus.start = 1'b0;
                bus.a     = 32'hDEADBEEF;
                bus.b     = 32'hCAFEF00D;
            end else if (inject && e == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MTLO;
                bus.a     = 32'h0000_1234;
            end else if (inject && e == 6) begin
                bus.start = 1'b0;
            end
            if (bus.busy) bc++;
            if (bus.done) break;
        end
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a, input string tag);
        drive(op, a, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done"}, 64'(bus.done), 64'h1);
        check({tag, "_busy"}, 64'(bus.busy), 64'h0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'h0000_0000;
        bus.b     = 32'h0000_0000;
        repeat (2) @(negedge clk);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        check("rst_busy", 64'(bus.busy), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        drive(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0007);
        wait_done(1'b0, edges, busy_cnt);
        check("mult_latency", 64'(edges), 64'd34);
        check("mult_busy_len", 64'(busy_cnt), 64'd33);
        check("mult_busy_end", 64'(bus.busy), 64'h0);
        check("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF9);
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'h0);

        drive(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, edges, busy_cnt);
        check("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        drive(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(1'b0, edges, busy_cnt);
        check("mult_minint", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
        @(negedge clk);

        move_to(OP_MTHI, 32'h0000_0001, "mthi");
        check("mthi_val", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
        move_to(OP_MTLO, 32'hFFFF_FFFF, "mtlo");
        check("mtlo_val", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFF);
        drive(OP_MADD, 32'h0000_0001, 32'h0000_0001);
        wait_done(1'b0, edges, busy_cnt);
        check("madd_carry", {bus.hi, bus.lo}, 64'h0000_0002_0000_0000);
        @(negedge clk);
        drive(OP_MSUB, 32'h0000_0001, 32'h0000_0001);
        wait_done(1'b0, edges, busy_cnt);
        check("msub_borrow", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFF);
        @(negedge clk);
        drive(OP_MSUB, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(1'b0, edges, busy_cnt);
        check("msub_neg", {bus.hi, bus.lo}, 64'h0000_0002_0000_0005);
        @(negedge clk);

        drive(OP_MULT, 32'h0000_0003, 32'h0000_0005);
        wait_done(1'b1, edges, busy_cnt);
        check("busy_start_lat", 64'(edges), 64'd34);
        check("busy_start_ign", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);

        // second request lands on the Done cycle of the first
        @(negedge clk);
        drive(OP_MULT, 32'h0000_0007, 32'h0000_0009);
        wait_done(1'b0, edges, busy_cnt);
        check("chain_first", {bus.hi, bus.lo}, 64'h0000_0000_0000_003F);
        drive(OP_MULT, 32'h0000_0002, 32'h0000_0002);
        wait_done(1'b0, edges, busy_cnt);
        check("chain_latency", 64'(edges), 64'd34);
        check("chain_second", {bus.hi, bus.lo}, 64'h0000_0000_0000_0004);
        @(negedge clk);

        drive(3'b111, 32'h5555_5555, 32'h0000_0003);
        @(posedge clk);
        @(negedge clk);
        check("rsvd7_done", 64'(bus.done), 64'h0);
        check("rsvd7_busy", 64'(bus.busy), 64'h0);
        bus.op = 3'b110;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("rsvd6_done", 64'(bus.done), 64'h0);
        check("rsvd_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_0004);

        move_to(OP_MTHI, 32'hA5A5_A5A5, "mthi2");
        drive(OP_MULT, 32'h0000_0005, 32'h0000_0007);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_pre", 64'(bus.busy), 64'h1);
        check("abort_hilo_pre", {bus.hi, bus.lo}, 64'hA5A5_A5A5_0000_0004);
        reset = 1'b0;
        #1;
        check("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        check("abort_busy", 64'(bus.busy), 64'h0);
        check("abort_done", 64'(bus.done), 64'h0);
        @(negedge clk);
        reset    = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'h0);
        check("abort_hilo_post", {bus.hi, bus.lo}, 64'h0);
        check("abort_busy_post", 64'(bus.busy), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
Multi-cycle multiply/accumulate unit and HI/LO register pair in the EX stage, beside the 32-bit ALU. It executes mult, multu, madd, msub, mthi and mtlo using an iterative radix-2 shift-add core. It holds the architectural HI/LO registers that mfhi/mflo read. It raises Busy so the hazard unit can stall the pipeline while a product is computed.

Parameters:
DATA_W, 32, operand and HI/LO width; product width is 2*DATA_W; iteration count equals DATA_W.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
Start  in  1  request strobe; sampled only when Busy=0
Op  in  3  operation: 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, others reserved
A  in  DATA_W  rs operand
B  in  DATA_W  rt operand; ignored for MTHI/MTLO
Busy  out  1  high while a multiply is in flight
Done  out  1  one-cycle pulse on the cycle an operation commits
Hi  out  DATA_W  registered HI
Lo  out  DATA_W  registered LO

Behaviour:
- Reset (Reset=0, asynchronous): Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE, counter=0.
  - Reset mid-operation aborts the operation with no commit.
- FSM states: IDLE, CALC, FIX.
- IDLE with Start=1 and Op=MTHI or MTLO, at edge N:
  - Hi<=A (MTHI) or Lo<=A (MTLO); the other register is unchanged.
  - Done=1 during cycle N..N+1. Busy stays 0. Stay in IDLE.
- IDLE with Start=1 and a multiply Op, at edge N:
  - Latch |A| and |B|. Signed ops take the two's-complement magnitude; MULTU uses raw values.
  - Latch neg = (A[31]^B[31]) for signed ops, 0 for MULTU. Latch Op.
  - Clear the 64-bit product accumulator, counter=0, go to CALC. Busy=1 from N onward.
- CALC: each edge adds the shifted multiplicand when the current multiplier bit is 1, then increments the counter.
  - After DATA_W edges (edge N+32), go to FIX.
- FIX, at edge N+33:
  - p = neg ? -prod : prod (64-bit).
  - MULT/MULTU: {Hi,Lo}<=p. MADD: {Hi,Lo}<=({Hi,Lo}+p) mod 2^64. MSUB: {Hi,Lo}<=({Hi,Lo}-p) mod 2^64.
  - Done=1 for one cycle, Busy=0 in the same cycle, FSM=IDLE.
- Multiply latency: Start accepted at edge N; result visible on Hi/Lo after edge N+33. Busy is high for 33 cycles.
- Hi/Lo hold their old values throughout CALC. Reads (mfhi/mflo) during Busy return stale data; stalling them is the hazard unit's job.
- Start while Busy=1 is ignored: no queueing, no effect on the in-flight op.
- Start with a reserved Op: ignored, no Done, no state change.
- Start is accepted on the IDLE cycle right after a Done. Back-to-back ops have a zero-cycle gap.
- Operand changes after the Start edge have no effect, because operands are latched.
- Arithmetic: 64-bit with wrap-around and no overflow flag, matching MIPS32 madd/msub semantics.

Decomposition:
- Shared package (hilo_pkg): Op encodings (OP_MULT..OP_MTLO), FSM state encodings, DATA_W default.
- One natural sub-module: iter_mult_core.
  - Unsigned DATA_W x DATA_W shift-add engine with load/step/done, exposing a 2*DATA_W product.
  - hilo_mult_unit wraps it with the sign handling, the accumulate logic and the HI/LO registers.

Test Plan:
1. Reset low mid-CALC (10 cycles after a MULT Start) -> Busy=0, Hi=Lo=0 immediately, with no Done after Reset rises.
2. MULT A=0xFFFFFFFF(-1), B=0x00000007 -> Done exactly 34 edges after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFF9.
3. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Also MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0.
4. MTHI A=0x00000001, then MTLO A=0xFFFFFFFF, then MADD A=1, B=1 -> Hi=0x00000002, Lo=0x00000000 (carry across LO wrap). Then MSUB A=1, B=1 -> Hi=0x00000001, Lo=0xFFFFFFFF.
5. Start MULT A=3, B=5; pulse Start with MTLO A=0x1234 at cycle 5 while Busy -> MTLO ignored; final Hi=0, Lo=0x0000000F.
6. Done-cycle Start: issue MULT A=2, B=2 on the cycle Done pulses for a prior MULT -> accepted; second result Lo=4 after a further 34 edges. Reserved Op=111 -> no Done, Hi/Lo unchanged.
